led_sequencer: RTL and testbench

Button-driven RGB LED controller for the board-level sample designs. It sits between the board wrapper's active-high push-button outputs and its active-high LED inputs, and replaces a purely combinational button-to-LED decode. It debounces both buttons and runs a three-mode state machine (off, manual color step, auto color rotation). It drives the single active color through a PWM brightness stage.

---
 rtl/led_sequencer_pkg.sv | 25 ++
 rtl/led_sequencer_if.sv | 23 ++
 rtl/button_debounce.sv | 56 +++++
 rtl/led_sequencer.sv | 120 ++++++++++++
 tb/tb_led_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED sequencer: operating modes, colors and the
// color rotation order used by both manual stepping and auto rotation.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_AUTO   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    COLOR_RED   = 2'd0,
    COLOR_GREEN = 2'd1,
    COLOR_BLUE  = 2'd2
  } color_e;

  function automatic color_e nextColor(input color_e c);
    case (c)
      COLOR_RED:   nextColor = COLOR_GREEN;
      COLOR_GREEN: nextColor = COLOR_BLUE;
      default:     nextColor = COLOR_RED;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Board-side bundle of the sequencer: raw push-buttons in, RGB LEDs and mode out.
// The board wrapper (or bench) is the master; the sequencer is the slave.
interface led_sequencer_if;
  import led_sequencer_pkg::*;

  logic  push_button0;
  logic  push_button1;
  logic  led_red;
  logic  led_green;
  logic  led_blue;
  mode_e mode;

  modport master (
    output push_button0, push_button1,
    input  led_red, led_green, led_blue, mode
  );

  modport slave (
    input  push_button0, push_button1,
    output led_red, led_green, led_blue, mode
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, level debouncer and registered press pulse for one
// bouncing active-high button; releases produce no pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncMeta_q;
  logic          syncLevel_q;
  logic          level_q, level_d;
  logic          levelPrev_q;
  logic          press_q;
  logic [CW-1:0] count_q, count_d;

  // Any cycle where the synchronized level agrees with the accepted one
  // restarts the stability count from zero.
  always_comb begin
    count_d = '0;
    level_d = level_q;
    if (syncLevel_q != level_q) begin
      if (count_q == COUNT_LAST) begin
        level_d = syncLevel_q;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      syncMeta_q  <= 1'b0;
      syncLevel_q <= 1'b0;
      level_q     <= 1'b0;
      levelPrev_q <= 1'b0;
      press_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      syncMeta_q  <= raw_i;
      syncLevel_q <= syncMeta_q;
      level_q     <= level_d;
      levelPrev_q <= level_q;
      press_q     <= level_q & ~levelPrev_q;
      count_q     <= count_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Button-driven RGB LED sequencer: OFF / MANUAL color step / AUTO rotation,
// with the single active color driven through a PWM brightness stage.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_CYCLES     = 12500000,
  parameter int PWM_BITS        = 4
) (
  input logic            clock,
  input logic            reset_n,
  led_sequencer_if.slave bus
);

  localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]     TIMER_LAST  = TW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS:0] BRIGHT_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS:0] BRIGHT_MIN  = {{PWM_BITS{1'b0}}, 1'b1};

  logic press0;
  logic press1;

  mode_e                mode_q, mode_d;
  color_e               color_q, color_d;
  logic [PWM_BITS:0]    bright_q, bright_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [PWM_BITS-1:0]  pwm_q;
  logic [2:0]           led_q, led_d;
  logic                 ledOn;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce0 (
    .clock   (clock),
    .reset_n (reset_n),
    .raw_i   (bus.push_button0),
    .press_o (press0)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce1 (
    .clock   (clock),
    .reset_n (reset_n),
    .raw_i   (bus.push_button1),
    .press_o (press1)
  );

  // press1 always wins a same-cycle collision, so press0 is only looked at
  // when press1 is idle.
  always_comb begin
    mode_d   = mode_q;
    color_d  = color_q;
    bright_d = bright_q;
    timer_d  = '0;
    case (mode_q)
      MODE_OFF: begin
        if (press1) mode_d = MODE_MANUAL;
      end
      MODE_MANUAL: begin
        if (press1) begin
          mode_d = MODE_AUTO;
        end else if (press0) begin
          color_d = nextColor(color_q);
        end
      end
      MODE_AUTO: begin
        if (press1) begin
          mode_d   = MODE_OFF;
          color_d  = COLOR_RED;
          bright_d = BRIGHT_FULL;
        end else begin
          if (timer_q == TIMER_LAST) begin
            color_d = nextColor(color_q);
          end else begin
            timer_d = timer_q + TW'(1);
          end
          if (press0) begin
            bright_d = (bright_q == BRIGHT_MIN) ? BRIGHT_FULL : (bright_q >> 1);
          end
        end
      end
      default: mode_d = MODE_OFF;
    endcase
  end

  // Brightness 2^PWM_BITS exceeds every counter value, giving a steady level.
  always_comb begin
    led_d = 3'b000;
    ledOn = (mode_q != MODE_OFF) && ({1'b0, pwm_q} < bright_q);
    if (ledOn) begin
      case (color_q)
        COLOR_RED:   led_d = 3'b001;
        COLOR_GREEN: led_d = 3'b010;
        COLOR_BLUE:  led_d = 3'b100;
        default:     led_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_OFF;
      color_q  <= COLOR_RED;
      bright_q <= BRIGHT_FULL;
      timer_q  <= '0;
      pwm_q    <= '0;
      led_q    <= 3'b000;
    end else begin
      mode_q   <= mode_d;
      color_q  <= color_d;
      bright_q <= bright_d;
      timer_q  <= timer_d;
      pwm_q    <= pwm_q + PWM_BITS'(1);
      led_q    <= led_d;
    end
  end

  assign bus.led_red   = led_q[0];
  assign bus.led_green = led_q[1];
  assign bus.led_blue  = led_q[2];
  assign bus.mode      = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: a directed vector table, hand-written
// latency/reset sequences and randomized presses, all against a cycle model.
module tb_led_sequencer;

  localparam int DEB    = 4;
  localparam int STEP   = 8;
  localparam int PWMB   = 4;
  localparam int PERIOD = 16;
  localparam int LAT    = DEB + 4;
  localparam int CLEAN  = DEB + 2;

  typedef struct {
    bit b0;
    bit b1;
    int hold;
    int rep;
    int expMode;
    int expColor;
    int expSum;
  } vector_t;

  typedef struct {
    int at;
    bit b0;
    bit b1;
  } event_t;

  logic clock;
  logic reset_n;

  led_sequencer_if bus ();

  led_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .STEP_CYCLES     (STEP),
    .PWM_BITS        (PWMB)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  vector_t    vectors [18];
  event_t     evq [$];
  int         checks;
  int         errors;
  int         cyc;
  int         mMode;
  int         mColor;
  int         mBright;
  int         autoBase;
  int         autoEntry;
  int         expMode;
  logic [2:0] expLeds;

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model color: AUTO advances once every STEP cycles measured from entry.
  function automatic int colorAt(input int e);
    if (mMode == 2) return (autoBase + (e - autoEntry) / STEP) % 3;
    return mColor;
  endfunction

  task automatic resetModel();
    cyc       = 0;
    mMode     = 0;
    mColor    = 0;
    mBright   = PERIOD;
    autoBase  = 0;
    autoEntry = 0;
    expMode   = 0;
    expLeds   = 3'b000;
    evq.delete();
  endtask

  // LEDs after edge e reflect state and PWM phase after edge e-1; PWM phase
  // is simply the number of edges since reset modulo the period.
  task automatic advanceModel();
    int e;
    int c;
    bit p0;
    bit p1;
    e = cyc + 1;
    c = colorAt(e - 1);
    expLeds = 3'b000;
    if (mMode != 0 && ((e - 1) % PERIOD) < mBright) expLeds = 3'(1 << c);
    cyc = e;
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].at == e) begin
        p0 = p0 | evq[i].b0;
        p1 = p1 | evq[i].b1;
        evq.delete(i);
      end
    end
    if (p1) begin
      if (mMode == 0) begin
        mMode = 1;
      end else if (mMode == 1) begin
        autoBase  = mColor;
        autoEntry = e;
        mMode     = 2;
      end else begin
        mMode   = 0;
        mColor  = 0;
        mBright = PERIOD;
      end
    end else if (p0) begin
      if (mMode == 1) mColor = (mColor + 1) % 3;
      else if (mMode == 2) mBright = (mBright == 1) ? PERIOD : mBright / 2;
    end
    expMode = mMode;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every cycle: advance the model on the rising edge, compare on the falling edge.
  task automatic monitorLoop();
    forever begin
      @(posedge clock);
      if (!reset_n) resetModel();
      else advanceModel();
      @(negedge clock);
      if (!reset_n) resetModel();
      checkOutput("mode", int'(bus.mode), expMode);
      checkOutput("leds", int'({bus.led_blue, bus.led_green, bus.led_red}), int'(expLeds));
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic schedulePress(input int at, input bit b0, input bit b1);
    event_t ev;
    ev.at = at;
    ev.b0 = b0;
    ev.b1 = b1;
    evq.push_back(ev);
  endtask

  // Raw buttons rise just after the current edge; a hold of CLEAN or more
  // cycles is a real press whose effect lands LAT edges later.
  task automatic applyStimulus(input bit b0, input bit b1, input int hold, input int gap);
    if (hold > 0) begin
      bus.push_button0 = b0;
      bus.push_button1 = b1;
      if (hold >= CLEAN) schedulePress(cyc + LAT, b0, b1);
      waitEdges(hold);
      bus.push_button0 = 1'b0;
      bus.push_button1 = 1'b0;
    end
    waitEdges(gap);
  endtask

  // Over any PERIOD-cycle window the lit cycles across all three LEDs equal
  // the brightness, even while AUTO rotates the color.
  task automatic windowCheck(input int row, input int eMode, input int eColor, input int eSum);
    int cnt [3];
    int sum;
    checkOutput($sformatf("vec%0d mode", row), int'(bus.mode), eMode);
    cnt = '{0, 0, 0};
    repeat (PERIOD) begin
      @(negedge clock);
      cnt[0] += int'(bus.led_red);
      cnt[1] += int'(bus.led_green);
      cnt[2] += int'(bus.led_blue);
    end
    sum = cnt[0] + cnt[1] + cnt[2];
    checkOutput($sformatf("vec%0d duty", row), sum, eSum);
    if (eColor >= 0) checkOutput($sformatf("vec%0d color", row), cnt[eColor], eSum);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int kind;
    vectors[0]  = '{0, 0, 0,     1, 0, -1, 0};
    vectors[1]  = '{0, 1, CLEAN, 1, 1,  0, 16};
    vectors[2]  = '{1, 0, 3,     5, 1,  0, 16};
    vectors[3]  = '{1, 0, CLEAN, 1, 1,  1, 16};
    vectors[4]  = '{1, 0, CLEAN, 1, 1,  2, 16};
    vectors[5]  = '{1, 0, CLEAN, 1, 1,  0, 16};
    vectors[6]  = '{0, 1, CLEAN, 1, 2, -1, 16};
    vectors[7]  = '{1, 0, CLEAN, 1, 2, -1, 8};
    vectors[8]  = '{1, 0, CLEAN, 1, 2, -1, 4};
    vectors[9]  = '{1, 0, CLEAN, 1, 2, -1, 2};
    vectors[10] = '{1, 0, CLEAN, 1, 2, -1, 1};
    vectors[11] = '{1, 0, CLEAN, 1, 2, -1, 16};
    vectors[12] = '{1, 0, CLEAN, 1, 2, -1, 8};
    vectors[13] = '{0, 1, CLEAN, 1, 0, -1, 0};
    vectors[14] = '{0, 1, CLEAN, 1, 1,  0, 16};
    vectors[15] = '{1, 0, CLEAN, 1, 1,  1, 16};
    vectors[16] = '{1, 1, CLEAN, 1, 2, -1, 16};
    vectors[17] = '{0, 1, CLEAN, 1, 0, -1, 0};

    checks           = 0;
    errors           = 0;
    reset_n          = 1'b1;
    bus.push_button0 = 1'b0;
    bus.push_button1 = 1'b0;
    resetModel();
    fork
      monitorLoop();
    join_none

    #3 reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      bus.push_button0 = i[0];
      bus.push_button1 = ~i[0];
    end
    bus.push_button0 = 1'b0;
    bus.push_button1 = 1'b0;
    waitEdges(2);
    reset_n = 1'b1;
    waitEdges(4);

    for (int r = 0; r < 18; r++) begin
      for (int k = 0; k < vectors[r].rep; k++) begin
        applyStimulus(vectors[r].b0, vectors[r].b1, vectors[r].hold, 12);
      end
      windowCheck(r, vectors[r].expMode, vectors[r].expColor, vectors[r].expSum);
    end

    $display("[TB] hand sequence: press latency into MANUAL");
    bus.push_button1 = 1'b1;
    schedulePress(cyc + LAT, 1'b0, 1'b1);
    waitEdges(LAT - 1);
    checkOutput("latency mode before", int'(bus.mode), 0);
    waitEdges(1);
    checkOutput("latency mode at", int'(bus.mode), 1);
    checkOutput("latency red before", int'(bus.led_red), 0);
    waitEdges(1);
    checkOutput("latency red at", int'(bus.led_red), 1);
    bus.push_button1 = 1'b0;
    waitEdges(14);

    $display("[TB] hand sequence: reset during debounce");
    bus.push_button1 = 1'b1;
    waitEdges(4);
    reset_n = 1'b0;
    #1;
    checkOutput("reset mode", int'(bus.mode), 0);
    checkOutput("reset leds", int'({bus.led_blue, bus.led_green, bus.led_red}), 0);
    waitEdges(2);
    reset_n = 1'b1;
    schedulePress(cyc + LAT, 1'b0, 1'b1);
    waitEdges(LAT - 1);
    checkOutput("partial count mode before", int'(bus.mode), 0);
    waitEdges(1);
    checkOutput("partial count mode at", int'(bus.mode), 1);
    bus.push_button1 = 1'b0;
    waitEdges(14);

    $display("[TB] randomized presses and glitches");
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: applyStimulus(1'b1, 1'b0, int'($urandom_range(CLEAN, 10)), int'($urandom_range(10, 20)));
        1: applyStimulus(1'b0, 1'b1, int'($urandom_range(CLEAN, 10)), int'($urandom_range(10, 20)));
        2: applyStimulus(1'b1, 1'b1, int'($urandom_range(CLEAN, 10)), int'($urandom_range(10, 20)));
        3: applyStimulus(1'b1, 1'b0, int'($urandom_range(1, DEB - 1)), int'($urandom_range(8, 12)));
        default: applyStimulus(1'b0, 1'b1, int'($urandom_range(1, DEB - 1)), int'($urandom_range(8, 12)));
      endcase
    end
    waitEdges(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
